// File: rtl/conv_lmem_resp_if.sv
// Bus bundle between the CONV initiator / dump host (master) and the
// layer-memory responder (slave).
interface conv_lmem_resp_if #(
  parameter int DW = 20,
  parameter int AW = 12
);
  logic          busy;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;
  logic          dump_req;
  logic [2:0]    dump_sel;
  logic          dump_valid;
  logic [DW-1:0] dump_data;
  logic [AW-1:0] dump_addr;
  logic          dump_last;
  logic          dump_ready;
  logic [4:0]    wr_flag;
  logic          oor_err;

  modport master (
    output busy, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
           dump_req, dump_sel, dump_ready,
    input  cdata_rd, dump_valid, dump_data, dump_addr, dump_last,
           wr_flag, oor_err
  );

  modport slave (
    input  busy, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
           dump_req, dump_sel, dump_ready,
    output cdata_rd, dump_valid, dump_data, dump_addr, dump_last,
           wr_flag, oor_err
  );
endinterface

// File: rtl/conv_lmem_resp.sv
// CONV layer-memory responder: five csel-addressed result banks packed into
// one flat array, a registered host read port, and a valid/ready dump stream
// (read stage -> output register + 1-entry skid) available once a run is done.
// Optional: define CONV_MEM_BYPASS_EN to forward same-cycle write data to a
// read of the same bank/address instead of returning the old word.
module conv_lmem_resp #(
  parameter int DW     = 20,
  parameter int AW     = 12,
  parameter int L0_DEP = 4096,
  parameter int L1_DEP = 1024,
  parameter int L2_DEP = 2048
) (
  input logic             clk,
  input logic             reset,
  conv_lmem_resp_if.slave bus
);

  localparam int TOTAL = 2*L0_DEP + 2*L1_DEP + L2_DEP;
  localparam int IW    = $clog2(TOTAL);
  localparam int DEPW  = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE, DUMP} state_t;

  state_t state_q, state_d;
  logic   dumping, enter_run, dump_start;

  logic [DW-1:0] mem [TOTAL];

  logic          wr_ok, rd_ok, oor_evt;
  logic [IW-1:0] wr_idx, rd_idx, dump_idx;
  logic [4:0]    wr_set;
  logic [DW-1:0] cdata_q;
  logic [4:0]    wr_flag_q;
  logic          oor_q;

  logic [2:0]      dsel_q;
  logic [DEPW-1:0] rd_ptr;
  logic            issue, accept;
  logic [1:0]      occ;
  logic            mem_v, mem_l, skid_v, skid_l, out_v, out_l;
  logic [DW-1:0]   mem_d, skid_d, out_d;
  logic [AW-1:0]   mem_a, skid_a, out_a;

  // Depth of each bank; invalid selects report zero so every address misses.
  function automatic logic [DEPW-1:0] bank_depth(input logic [2:0] sel);
    case (sel)
      3'd1, 3'd2: bank_depth = DEPW'(L0_DEP);
      3'd3, 3'd4: bank_depth = DEPW'(L1_DEP);
      3'd5:       bank_depth = DEPW'(L2_DEP);
      default:    bank_depth = '0;
    endcase
  endfunction

  // Start offset of each bank inside the flat array.
  function automatic logic [IW-1:0] bank_base(input logic [2:0] sel);
    case (sel)
      3'd2:    bank_base = IW'(L0_DEP);
      3'd3:    bank_base = IW'(2*L0_DEP);
      3'd4:    bank_base = IW'(2*L0_DEP + L1_DEP);
      3'd5:    bank_base = IW'(2*L0_DEP + 2*L1_DEP);
      default: bank_base = '0;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: dump request wins over a new run when both arrive in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.busy) state_d = RUN;
      RUN:  if (!bus.busy) state_d = DONE;
      DONE: begin
        if (bus.dump_req && (bank_depth(bus.dump_sel) != '0)) state_d = DUMP;
        else if (bus.busy)                                    state_d = RUN;
      end
      DUMP: if (accept && out_l) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // FSM-derived control strobes.
  always_comb begin
    dumping    = (state_q == DUMP);
    enter_run  = (state_d == RUN) && (state_q != RUN);
    dump_start = (state_q == DONE) && (state_d == DUMP);
  end

  // Host access decode: range check against the selected bank, blocked while dumping.
  always_comb begin
    wr_ok    = bus.cwr && !dumping && ({1'b0, bus.caddr_wr} < bank_depth(bus.csel));
    rd_ok    = bus.crd && !dumping && ({1'b0, bus.caddr_rd} < bank_depth(bus.csel));
    oor_evt  = (bus.cwr && !wr_ok) || (bus.crd && !rd_ok);
    wr_idx   = bank_base(bus.csel) + IW'(bus.caddr_wr);
    rd_idx   = bank_base(bus.csel) + IW'(bus.caddr_rd);
    dump_idx = bank_base(dsel_q) + IW'(rd_ptr[AW-1:0]);
    wr_set   = wr_ok ? (5'b00001 << (bus.csel - 3'd1)) : 5'b00000;
  end

`ifdef CONV_MEM_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = wr_ok && rd_ok && (bus.caddr_wr == bus.caddr_rd);
`endif

  // Memory array (not reset): host write port plus the dump read stage.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= bus.cdata_wr;
    if (issue) mem_d <= mem[dump_idx];
  end

  // Host read data register; holds its value while crd is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      cdata_q <= '0;
    end else if (bus.crd) begin
      if (!rd_ok)          cdata_q <= '0;
`ifdef CONV_MEM_BYPASS_EN
      else if (bypass_hit) cdata_q <= bus.cdata_wr;
`endif
      else                 cdata_q <= mem[rd_idx];
    end
  end

  // Sticky status flags, cleared whenever a new run begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_flag_q <= '0;
      oor_q     <= 1'b0;
    end else begin
      wr_flag_q <= (enter_run ? 5'b00000 : wr_flag_q) | wr_set;
      oor_q     <= (enter_run ? 1'b0 : oor_q) | oor_evt;
    end
  end

  // Dump flow control: occupancy of read stage + output + skid never exceeds two,
  // so a word leaving the read stage always has a free slot.
  always_comb begin
    accept = out_v && bus.dump_ready;
    occ    = 2'(mem_v) + 2'(out_v) + 2'(skid_v);
    issue  = dumping && (rd_ptr < bank_depth(dsel_q)) && ((occ < 2'd2) || accept);
  end

  // Dump pipeline: address counter, read-stage tags, output register and skid.
  always_ff @(posedge clk) begin
    if (reset) begin
      dsel_q <= '0;
      rd_ptr <= '0;
      mem_v  <= 1'b0;
      mem_a  <= '0;
      mem_l  <= 1'b0;
      skid_v <= 1'b0;
      skid_d <= '0;
      skid_a <= '0;
      skid_l <= 1'b0;
      out_v  <= 1'b0;
      out_d  <= '0;
      out_a  <= '0;
      out_l  <= 1'b0;
    end else begin
      if (dump_start)  begin
        dsel_q <= bus.dump_sel;
        rd_ptr <= '0;
      end else if (issue) begin
        rd_ptr <= rd_ptr + DEPW'(1);
      end
      mem_v <= issue;
      if (issue) begin
        mem_a <= rd_ptr[AW-1:0];
        mem_l <= (rd_ptr == (bank_depth(dsel_q) - DEPW'(1)));
      end
      if (!out_v || accept) begin
        if (skid_v) begin
          out_v <= 1'b1;
          out_d <= skid_d;
          out_a <= skid_a;
          out_l <= skid_l;
          if (mem_v) begin
            skid_d <= mem_d;
            skid_a <= mem_a;
            skid_l <= mem_l;
          end else begin
            skid_v <= 1'b0;
          end
        end else if (mem_v) begin
          out_v <= 1'b1;
          out_d <= mem_d;
          out_a <= mem_a;
          out_l <= mem_l;
        end else begin
          out_v <= 1'b0;
          out_l <= 1'b0;
        end
      end else if (mem_v) begin
        skid_v <= 1'b1;
        skid_d <= mem_d;
        skid_a <= mem_a;
        skid_l <= mem_l;
      end
    end
  end

  assign bus.cdata_rd   = cdata_q;
  assign bus.dump_valid = out_v;
  assign bus.dump_data  = out_d;
  assign bus.dump_addr  = out_a;
  assign bus.dump_last  = out_l;
  assign bus.wr_flag    = wr_flag_q;
  assign bus.oor_err    = oor_q;

endmodule

// File: tb/tb_conv_lmem_resp.sv
// Testbench for conv_lmem_resp: directed scenarios plus randomized host
// traffic and dump streams, checked against a per-bank array model.
module tb_conv_lmem_resp;
  localparam int DW = 20;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  conv_lmem_resp_if #(.DW(DW), .AW(AW)) bus ();

  conv_lmem_resp #(
    .DW(DW), .AW(AW), .L0_DEP(4096), .L1_DEP(1024), .L2_DEP(2048)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [DW-1:0] ref_mem   [1:5][4096];
  bit            ref_known [1:5][4096];
  logic [4:0]    m_wr_flag;
  logic          m_oor;
  bit            in_dump;
  bit            busy_m;

  // Bank depth as the host sees it; zero for selects that name no bank.
  function automatic int depth_of(input logic [2:0] s);
    case (s)
      3'd1, 3'd2: return 4096;
      3'd3, 3'd4: return 1024;
      3'd5:       return 2048;
      default:    return 0;
    endcase
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlags();
    checkOutput("wr_flag", 32'(bus.wr_flag), 32'(m_wr_flag));
    checkOutput("oor_err", 32'(bus.oor_err), 32'(m_oor));
  endtask

  // Reference behaviour of one host cycle: returns the expected read word
  // (when it is knowable) and updates bank contents and sticky flags.
  task automatic modelAccess(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input bit r, input logic [AW-1:0] ra, input logic [2:0] s,
                             output bit chk, output logic [DW-1:0] exp);
    int dep;
    dep = depth_of(s);
    chk = 1'b0;
    exp = '0;
    if (r) begin
      if (in_dump || int'(ra) >= dep) begin
        chk   = 1'b1;
        exp   = '0;
        m_oor = 1'b1;
      end else begin
`ifdef CONV_MEM_BYPASS_EN
        if (w && wa == ra) begin
          chk = 1'b1;
          exp = wd;
        end else
`endif
        if (ref_known[s][ra]) begin
          chk = 1'b1;
          exp = ref_mem[s][ra];
        end
      end
    end
    if (w) begin
      if (in_dump || int'(wa) >= dep) begin
        m_oor = 1'b1;
      end else begin
        ref_mem[s][wa]   = wd;
        ref_known[s][wa] = 1'b1;
        m_wr_flag[s-1]   = 1'b1;
      end
    end
  endtask

  // One host cycle on the write/read port, then check read data and flags.
  task automatic applyStimulus(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input bit r, input logic [AW-1:0] ra, input logic [2:0] s);
    bit chk;
    logic [DW-1:0] exp;
    bus.cwr      = w;
    bus.caddr_wr = wa;
    bus.cdata_wr = wd;
    bus.crd      = r;
    bus.caddr_rd = ra;
    bus.csel     = s;
    modelAccess(w, wa, wd, r, ra, s, chk, exp);
    tick();
    bus.cwr = 1'b0;
    bus.crd = 1'b0;
    if (chk) checkOutput("cdata_rd", 32'(bus.cdata_rd), 32'(exp));
    checkFlags();
  endtask

  task automatic setBusy(input bit b);
    bus.busy = b;
    if (b && !busy_m) begin
      m_wr_flag = '0;
      m_oor     = 1'b0;
    end
    busy_m = b;
    tick();
    checkFlags();
  endtask

  // Pulse dump_req and confirm no stream starts.
  task automatic reqIgnored(input string tag, input logic [2:0] s);
    bus.dump_sel = s;
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req = 1'b0;
    repeat (3) tick();
    checkOutput(tag, 32'(bus.dump_valid), 32'd0);
  endtask

  // Stream one bank. mode 0: ready always high, 1: ready toggling, 2: random.
  // inject_at: dump index at which a host write+read is attempted (dropped).
  // stop_at: dump index at which the task returns early (for a reset abort).
  task automatic runDump(input logic [2:0] sel, input int mode, input int inject_at,
                         input int stop_at, output bit stopped);
    int dep, idx, cyc, budget;
    bit rdy, stall, injected, inj_pending, chk;
    logic [DW-1:0] hd, exp;
    logic [AW-1:0] ha;
    logic hl;
    dep = depth_of(sel);
    idx = 0;
    cyc = 0;
    budget = dep * 4 + 100;
    stall = 1'b0;
    injected = 1'b0;
    inj_pending = 1'b0;
    stopped = 1'b0;
    hd = '0;
    ha = '0;
    hl = 1'b0;
    bus.dump_ready = (mode != 1);
    bus.dump_sel = sel;
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req = 1'b0;
    in_dump = 1'b1;
    checkOutput("dump_lat0", 32'(bus.dump_valid), 32'd0);
    tick();
    checkOutput("dump_lat1", 32'(bus.dump_valid), 32'd0);
    tick();
    checkOutput("dump_lat2", 32'(bus.dump_valid), 32'd1);
    while (idx < dep) begin
      if (inj_pending) begin
        inj_pending = 1'b0;
        checkOutput("dump_host_rd", 32'(bus.cdata_rd), 32'd0);
        checkFlags();
      end
      if (cyc >= budget) begin
        checkOutput("dump_timeout", idx, dep);
        break;
      end
      if (idx == stop_at) begin
        stopped = 1'b1;
        break;
      end
      if (stall) begin
        checkOutput("stall_valid", 32'(bus.dump_valid), 32'd1);
        checkOutput("stall_data", 32'(bus.dump_data), 32'(hd));
        checkOutput("stall_addr", 32'(bus.dump_addr), 32'(ha));
        checkOutput("stall_last", 32'(bus.dump_last), 32'(hl));
      end
      if (mode == 0) checkOutput("dump_rate", 32'(bus.dump_valid), 32'd1);
      if (bus.dump_valid) begin
        checkOutput("dump_addr", 32'(bus.dump_addr), idx);
        checkOutput("dump_data", 32'(bus.dump_data), 32'(ref_mem[sel][idx]));
        checkOutput("dump_last", 32'(bus.dump_last), 32'(idx == dep - 1));
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.dump_ready = rdy;
      if (!injected && idx == inject_at) begin
        injected = 1'b1;
        inj_pending = 1'b1;
        bus.cwr = 1'b1;
        bus.caddr_wr = '0;
        bus.cdata_wr = ~ref_mem[sel][0];
        bus.crd = 1'b1;
        bus.caddr_rd = '0;
        bus.csel = sel;
        modelAccess(1'b1, '0, ~ref_mem[sel][0], 1'b1, '0, sel, chk, exp);
      end
      stall = bus.dump_valid && !rdy;
      hd = bus.dump_data;
      ha = bus.dump_addr;
      hl = bus.dump_last;
      if (bus.dump_valid && rdy) idx++;
      tick();
      bus.cwr = 1'b0;
      bus.crd = 1'b0;
      cyc++;
    end
    if (!stopped) begin
      checkOutput("dump_end_valid", 32'(bus.dump_valid), 32'd0);
      in_dump = 1'b0;
    end
  endtask

  initial begin
    bit stopped;
    logic [2:0] s;
    logic [AW-1:0] wa, ra;
    bit w, r;

    bus.busy = 1'b0;
    bus.cwr = 1'b0;
    bus.caddr_wr = '0;
    bus.cdata_wr = '0;
    bus.crd = 1'b0;
    bus.caddr_rd = '0;
    bus.csel = '0;
    bus.dump_req = 1'b0;
    bus.dump_sel = '0;
    bus.dump_ready = 1'b0;
    reset = 1'b1;
    m_wr_flag = '0;
    m_oor = 1'b0;
    in_dump = 1'b0;
    busy_m = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    checkOutput("rst_cdata_rd", 32'(bus.cdata_rd), 32'd0);
    checkOutput("rst_dump_valid", 32'(bus.dump_valid), 32'd0);
    checkOutput("rst_dump_data", 32'(bus.dump_data), 32'd0);
    checkOutput("rst_dump_addr", 32'(bus.dump_addr), 32'd0);
    checkOutput("rst_dump_last", 32'(bus.dump_last), 32'd0);
    checkOutput("rst_wr_flag", 32'(bus.wr_flag), 32'd0);
    checkOutput("rst_oor_err", 32'(bus.oor_err), 32'd0);

    setBusy(1'b1);
    applyStimulus(1'b1, 12'h005, 20'h12345, 1'b0, 12'h000, 3'd1);
    applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'h005, 3'd1);
    checkOutput("t1_rd", 32'(bus.cdata_rd), 32'h12345);
    checkOutput("t1_flag", 32'(bus.wr_flag), 32'h01);

    applyStimulus(1'b1, 12'h400, 20'h0BEEF, 1'b0, 12'h000, 3'd3);
    checkOutput("t2_oor", 32'(bus.oor_err), 32'd1);
    applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'h400, 3'd3);
    checkOutput("t2_rd", 32'(bus.cdata_rd), 32'd0);

    applyStimulus(1'b1, 12'h7FF, 20'h00001, 1'b0, 12'h000, 3'd5);
    applyStimulus(1'b1, 12'h7FF, 20'h000AA, 1'b1, 12'h7FF, 3'd5);
`ifdef CONV_MEM_BYPASS_EN
    checkOutput("t3_same_cycle", 32'(bus.cdata_rd), 32'h000AA);
`else
    checkOutput("t3_same_cycle", 32'(bus.cdata_rd), 32'h00001);
`endif
    applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'h7FF, 3'd5);
    checkOutput("t3_new_word", 32'(bus.cdata_rd), 32'h000AA);
    applyStimulus(1'b1, 12'h010, 20'h55555, 1'b0, 12'h7FF, 3'd2);
    checkOutput("rd_hold", 32'(bus.cdata_rd), 32'h000AA);

    for (int i = 0; i < 300; i++) begin
      s  = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) ra = wa;
      applyStimulus(w, wa, 20'($urandom), r, ra, s);
    end

    for (int a = 0; a < 1024; a++) applyStimulus(1'b1, 12'(a), 20'($urandom), 1'b0, 12'h000, 3'd4);
    for (int a = 0; a < 4096; a++) applyStimulus(1'b1, 12'(a), 20'($urandom), 1'b0, 12'h000, 3'd2);

    reqIgnored("req_in_run", 3'd4);
    setBusy(1'b0);
    reqIgnored("req_bad_sel", 3'd6);

    runDump(3'd4, 0, -1, 1 << 20, stopped);
    runDump(3'd2, 1, -1, 1 << 20, stopped);

    setBusy(1'b1);
    checkOutput("run_clear_flag", 32'(bus.wr_flag), 32'd0);
    checkOutput("run_clear_oor", 32'(bus.oor_err), 32'd0);
    applyStimulus(1'b1, 12'h020, 20'h0F0F0, 1'b0, 12'h000, 3'd1);
    setBusy(1'b0);

    runDump(3'd4, 2, 50, 100, stopped);
    checkOutput("abort_reached", 32'(stopped), 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("abort_valid", 32'(bus.dump_valid), 32'd0);
    reset = 1'b0;
    bus.busy = 1'b0;
    busy_m = 1'b0;
    in_dump = 1'b0;
    m_wr_flag = '0;
    m_oor = 1'b0;
    checkOutput("abort_cdata", 32'(bus.cdata_rd), 32'd0);
    checkFlags();
    reqIgnored("req_in_idle", 3'd4);

    setBusy(1'b1);
    applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'h000, 3'd4);
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'($urandom_range(0, 1023)), 3'd4);
      applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'($urandom), 3'd2);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
